// File: rtl/bitwise_stream_unit.sv
// ---------------------------------------------------------------------------
// bitwise_stream_unit
//
// Registered WIDTH-bit bitwise logic unit with a per-bit write mask. Words
// enter through a valid/ready handshake, are transformed combinationally on
// the way in, and are held in a two-entry skid buffer (main + skid) so the
// unit sustains one word per cycle even when the consumer stalls.
//
// Parameters
//   WIDTH  data width in bits (>= 1)
//   CNT_W  width of the delivered-word counter (>= 1)
//
// Ports
//   clk        sole clock, all state updates on the rising edge
//   reset      synchronous, active-high reset
//   in_valid   source offers a word this cycle
//   in_ready   unit accepts a word this cycle (never depends on out_ready)
//   a, b       operands
//   op         operation select, sampled with the word
//   mask       per-bit enable; cleared bits pass operand a through
//   out_valid  result word available (main register occupied)
//   out_ready  consumer takes the word this cycle
//   out        result word from the main register
//   out_zero   out == 0
//   out_neg    most significant bit of out
//   count      number of delivered words, modulo 2^CNT_W
// ---------------------------------------------------------------------------
module bitwise_stream_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic             out_neg,
  output logic [CNT_W-1:0] count
);

  // Operation encodings for the op input.
  typedef enum logic [2:0] {
    OP_NOT  = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_XOR  = 3'b011,
    OP_NAND = 3'b100,
    OP_NOR  = 3'b101,
    OP_XNOR = 3'b110,
    OP_PASS = 3'b111
  } opCode_t;

  // Buffer occupancy: nothing held, main only, or main and skid both held.
  // The skid entry is only ever occupied while main is too.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_MAIN  = 2'b01,
    OCC_BOTH  = 2'b10
  } occState_t;

  occState_t occState_q, occState_d;

  logic [WIDTH-1:0] mainData_q, mainData_d;
  logic [WIDTH-1:0] skidData_q, skidData_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [WIDTH-1:0] funcResult;
  logic [WIDTH-1:0] maskedResult;

  logic mainValid;
  logic skidValid;
  logic accept;
  logic deliver;
  logic loadMainFromInput;
  logic loadMainFromSkid;
  logic loadSkidFromInput;

  // Raw bitwise function of the two operands, before masking.
  always_comb begin
    funcResult = '0;
    case (op)
      OP_NOT:  funcResult = ~a;
      OP_AND:  funcResult = a & b;
      OP_OR:   funcResult = a | b;
      OP_XOR:  funcResult = a ^ b;
      OP_NAND: funcResult = ~(a & b);
      OP_NOR:  funcResult = ~(a | b);
      OP_XNOR: funcResult = ~(a ^ b);
      OP_PASS: funcResult = a;
      default: funcResult = a;
    endcase
  end

  // Bits with a cleared mask keep operand a untouched.
  assign maskedResult = (funcResult & mask) | (a & ~mask);

  // Valid bits follow directly from the occupancy state.
  assign mainValid = (occState_q == OCC_MAIN) || (occState_q == OCC_BOTH);
  assign skidValid = (occState_q == OCC_BOTH);

  // in_ready only looks at the skid entry and reset, so there is no
  // combinational path from out_ready back to the source.
  assign in_ready  = !skidValid && !reset;
  assign out_valid = mainValid;

  assign accept  = in_valid && in_ready;
  assign deliver = mainValid && out_ready;

  // Occupancy state register; reset discards every held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      occState_q <= OCC_EMPTY;
    end else begin
      occState_q <= occState_d;
    end
  end

  // Next occupancy. Accept while full cannot happen because in_ready is low
  // whenever the skid entry is occupied.
  always_comb begin
    occState_d = occState_q;
    case (occState_q)
      OCC_EMPTY: begin
        if (accept) begin
          occState_d = OCC_MAIN;
        end
      end
      OCC_MAIN: begin
        if (accept && !deliver) begin
          occState_d = OCC_BOTH;
        end else if (!accept && deliver) begin
          occState_d = OCC_EMPTY;
        end
      end
      OCC_BOTH: begin
        if (deliver) begin
          occState_d = OCC_MAIN;
        end
      end
      default: occState_d = OCC_EMPTY;
    endcase
  end

  // Datapath steering decided from occupancy and this cycle's handshakes.
  // A new word goes into main when main is free or is leaving this cycle;
  // otherwise it parks in skid. Skid refills main as soon as main leaves.
  always_comb begin
    loadMainFromInput = 1'b0;
    loadMainFromSkid  = 1'b0;
    loadSkidFromInput = 1'b0;
    case (occState_q)
      OCC_EMPTY: begin
        loadMainFromInput = accept;
      end
      OCC_MAIN: begin
        loadMainFromInput = accept && deliver;
        loadSkidFromInput = accept && !deliver;
      end
      OCC_BOTH: begin
        loadMainFromSkid = deliver;
      end
      default: begin
        loadMainFromInput = 1'b0;
      end
    endcase
  end

  // Next values for the data registers and the delivered-word counter.
  always_comb begin
    mainData_d = mainData_q;
    skidData_d = skidData_q;
    count_d    = count_q;
    if (loadMainFromInput) begin
      mainData_d = maskedResult;
    end else if (loadMainFromSkid) begin
      mainData_d = skidData_q;
    end
    if (loadSkidFromInput) begin
      skidData_d = maskedResult;
    end
    if (deliver) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Data and counter registers. Main clears to zero so out_zero reads 1
  // straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mainData_q <= '0;
      skidData_q <= '0;
      count_q    <= '0;
    end else begin
      mainData_q <= mainData_d;
      skidData_q <= skidData_d;
      count_q    <= count_d;
    end
  end

  // Flags come from the main register, so they stay stable with the data
  // while the consumer stalls.
  assign out      = mainData_q;
  assign out_zero = (mainData_q == '0);
  assign out_neg  = mainData_q[WIDTH-1];
  assign count    = count_q;

endmodule

// File: tb/tb_bitwise_stream_unit.sv
module tb_bitwise_stream_unit;

  logic clk;

  // 16-bit unit with a 4-bit counter so the wrap is cheap to reach.
  logic        rst16, iv16, ir16, ov16, or16, oz16, on16;
  logic [15:0] a16, b16, m16, o16;
  logic [2:0]  op16;
  logic [3:0]  cnt16;

  // 8-bit unit used for the reset-with-full-buffer sequence.
  logic        rst8, iv8, ir8, ov8, or8, oz8, on8;
  logic [7:0]  a8, b8, m8, o8;
  logic [2:0]  op8;
  logic [15:0] cnt8;

  int testsRun = 0;
  int failures = 0;

  // Behavioural model: ordered list of words held by the unit.
  logic [15:0] mq[$];
  int          mcount = 0;
  int          nDel   = 0;
  logic        lastAcc, lastDel;
  logic [15:0] lastDelWord;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] mask;
    logic [15:0] expOut;
  } vec_t;

  vec_t        vecs[10];
  logic [15:0] recv[$];
  bit          pat[8];
  logic [15:0] nextWord;

  bitwise_stream_unit #(.WIDTH(16), .CNT_W(4)) u16 (
    .clk(clk), .reset(rst16), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .op(op16), .mask(m16),
    .out_valid(ov16), .out_ready(or16), .out(o16),
    .out_zero(oz16), .out_neg(on16), .count(cnt16)
  );

  bitwise_stream_unit #(.WIDTH(8), .CNT_W(16)) u8 (
    .clk(clk), .reset(rst8), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .op(op8), .mask(m8),
    .out_valid(ov8), .out_ready(or8), .out(o8),
    .out_zero(oz8), .out_neg(on8), .count(cnt8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Each opcode as a truth table over {a_bit, b_bit}; masked-off bits keep a.
  function automatic logic [15:0] refOp(input logic [2:0] o, input logic [15:0] x,
                                        input logic [15:0] y, input logic [15:0] m);
    logic [3:0]  tt;
    logic [15:0] r;
    case (o)
      3'd0:    tt = 4'b0011;
      3'd1:    tt = 4'b1000;
      3'd2:    tt = 4'b1110;
      3'd3:    tt = 4'b0110;
      3'd4:    tt = 4'b0111;
      3'd5:    tt = 4'b0001;
      3'd6:    tt = 4'b1001;
      default: tt = 4'b1100;
    endcase
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[i] = m[i] ? tt[{x[i], y[i]}] : x[i];
    end
    return r;
  endfunction

  // One clock cycle on the 16-bit unit: drive, compare against the model,
  // clock, then advance the model.
  task automatic applyStimulus(input logic rst, input logic iv, input logic [2:0] iop,
                               input logic [15:0] ia, input logic [15:0] ib,
                               input logic [15:0] im, input logic ordy);
    logic        acc, del;
    logic [15:0] r;
    rst16 = rst; iv16 = iv; op16 = iop; a16 = ia; b16 = ib; m16 = im; or16 = ordy;
    #1;
    checkOutput("in_ready", ir16, (!rst && mq.size() < 2));
    checkOutput("out_valid", ov16, (mq.size() > 0));
    checkOutput("count", cnt16, mcount);
    if (mq.size() > 0) begin
      checkOutput("out", o16, mq[0]);
      checkOutput("out_zero", oz16, (mq[0] == 16'h0));
      checkOutput("out_neg", on16, mq[0][15]);
    end
    acc = iv && !rst && (mq.size() < 2);
    del = !rst && (mq.size() > 0) && ordy;
    r = refOp(iop, ia, ib, im);
    lastAcc = acc;
    lastDel = del;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mcount = 0;
    end else begin
      if (del) begin
        lastDelWord = mq.pop_front();
        mcount = (mcount + 1) % 16;
        nDel++;
      end
      if (acc) mq.push_back(r);
    end
    @(negedge clk);
  endtask

  initial begin
    rst16 = 1'b1; iv16 = 1'b1; op16 = 3'd0; a16 = '0; b16 = '0; m16 = '0; or16 = 1'b0;
    rst8  = 1'b1; iv8  = 1'b0; op8  = 3'd0; a8  = '0; b8  = '0; m8  = '0; or8  = 1'b0;

    vecs[0] = '{3'b000, 16'h00FF, 16'h0000, 16'hFFFF, 16'hFF00};
    vecs[1] = '{3'b011, 16'hAAAA, 16'hFFFF, 16'h00FF, 16'hAA55};
    vecs[2] = '{3'b001, 16'h1234, 16'h0000, 16'hFFFF, 16'h0000};
    vecs[3] = '{3'b010, 16'h1200, 16'h0034, 16'hFFFF, 16'h1234};
    vecs[4] = '{3'b100, 16'hFFFF, 16'h0F0F, 16'hFFFF, 16'hF0F0};
    vecs[5] = '{3'b101, 16'h0F00, 16'h00F0, 16'hFFFF, 16'hF00F};
    vecs[6] = '{3'b110, 16'hFF00, 16'hF0F0, 16'hFFFF, 16'hF00F};
    vecs[7] = '{3'b111, 16'hBEEF, 16'h1234, 16'h0000, 16'hBEEF};
    vecs[8] = '{3'b000, 16'h0000, 16'h0000, 16'h0F0F, 16'h0F0F};
    vecs[9] = '{3'b001, 16'hFFFF, 16'h00FF, 16'hF0F0, 16'h0FFF};
    pat = '{1, 0, 0, 1, 0, 1, 1, 1};

    // Reset held for three edges with in_valid high throughout.
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 3'd7, 16'h1111, 16'h0, 16'hFFFF, 1'b1);
    applyStimulus(1'b1, 1'b1, 3'd7, 16'h2222, 16'h0, 16'hFFFF, 1'b1);
    checkOutput("reset out", o16, 16'h0000);
    checkOutput("reset out_zero", oz16, 1'b1);
    checkOutput("reset out_neg", on16, 1'b0);
    checkOutput("reset ready low", ir16, 1'b0);

    // Table of single operations with the consumer always ready.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].mask, 1'b1);
      checkOutput($sformatf("vec%0d out", i), o16, vecs[i].expOut);
      checkOutput($sformatf("vec%0d valid", i), ov16, 1'b1);
      checkOutput($sformatf("vec%0d zero", i), oz16, (vecs[i].expOut == 16'h0));
      checkOutput($sformatf("vec%0d neg", i), on16, vecs[i].expOut[15]);
      if (i == 1) checkOutput("count after first word", cnt16, 4'd1);
    end
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b1);

    // Backpressure stream of words 1..8 through PASS.
    recv.delete();
    nextWord = 16'd1;
    for (int c = 0; c < 40 && recv.size() < 8; c++) begin
      applyStimulus(1'b0, (nextWord <= 16'd8), 3'b111, nextWord, 16'h0, 16'hFFFF,
                    (c < 8) ? pat[c] : 1'b1);
      if (lastAcc) nextWord++;
      if (lastDel) recv.push_back(lastDelWord);
    end
    checkOutput("backpressure delivered", recv.size(), 8);
    for (int i = 0; i < recv.size(); i++) begin
      checkOutput($sformatf("backpressure order %0d", i), recv[i], i + 1);
    end

    // Counter wrap with a 4-bit counter: 17 deliveries after a reset.
    applyStimulus(1'b1, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0);
    nDel = 0;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b0, (i < 17), 3'b111, 16'(i + 100), 16'h0, 16'hFFFF, 1'b1);
      if (lastDel && nDel == 15) checkOutput("count at 15", cnt16, 4'd15);
      if (lastDel && nDel == 16) checkOutput("count at 16", cnt16, 4'd0);
      if (lastDel && nDel == 17) checkOutput("count at 17", cnt16, 4'd1);
    end
    checkOutput("wrap deliveries", nDel, 17);

    // Randomised traffic against the model, including occasional resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                    3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                    16'($urandom), ($urandom_range(0, 2) != 0));
    end

    // Reset of the 8-bit unit while both main and skid hold words.
    rst8 = 1'b0; iv8 = 1'b1; op8 = 3'b111; a8 = 8'h33; m8 = 8'hFF; or8 = 1'b1;
    @(posedge clk); @(negedge clk);
    checkOutput("u8 first word", o8, 8'h33);
    a8 = 8'h11;
    @(posedge clk); @(negedge clk);
    a8 = 8'h22; or8 = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("u8 full main", o8, 8'h11);
    checkOutput("u8 full ready", ir8, 1'b0);
    checkOutput("u8 count before reset", cnt8, 16'd1);
    rst8 = 1'b1; iv8 = 1'b1; a8 = 8'h55; or8 = 1'b1;
    #1;
    checkOutput("u8 ready in reset", ir8, 1'b0);
    @(posedge clk); @(negedge clk);
    checkOutput("u8 valid after reset", ov8, 1'b0);
    checkOutput("u8 count after reset", cnt8, 16'd0);
    checkOutput("u8 zero after reset", oz8, 1'b1);
    rst8 = 1'b0; iv8 = 1'b1; op8 = 3'b000; a8 = 8'h0F; b8 = 8'h00; m8 = 8'hFF; or8 = 1'b1;
    #1;
    checkOutput("u8 ready after reset", ir8, 1'b1);
    @(posedge clk); @(negedge clk);
    checkOutput("u8 not result", o8, 8'hF0);
    checkOutput("u8 not valid", ov8, 1'b1);
    checkOutput("u8 not neg", on8, 1'b1);
    iv8 = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("u8 count after deliver", cnt8, 16'd1);
    checkOutput("u8 drained", ov8, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
